cv32e41s_dummy_instr_burst: RTL and testbench



---
 rtl/cv32e41s_dummy_instr_burst.sv | 176 +++++++++++++++++
 tb/tb_cv32e41s_dummy_instr_burst.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_dummy_instr_burst.sv
// Dummy-instruction generator for the IF stage: decides when to insert a dummy
// (single-shot or burst) and produces the raw RV32 instruction word from an owned LFSR.
module cv32e41s_dummy_instr_burst #(
    parameter int unsigned MAX_INTERVAL = 64,
    parameter int unsigned BURST_W      = 3,
    parameter logic [31:0] LFSR_SEED    = 32'h2BAD_F00D,
    localparam int unsigned IW          = $clog2(MAX_INTERVAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic               allow_dummy_i,
    input  logic               boundary_i,
    input  logic               ptr_in_if_i,
    input  logic               instr_issued_i,
    input  logic               hint_shift_i,
    input  logic               cnt_rst_i,
    input  logic [IW-3:0]      freq_i,
    input  logic [3:0]         op_en_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic [31:0]        seed_i,
    input  logic               seed_we_i,
    output logic               dummy_insert_o,
    output logic [31:0]        dummy_instr_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        BURST = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_MUL  = 2'd1,
        OP_AND  = 2'd2,
        OP_BLTU = 2'd3
    } op_e;

    // Galois feedback for x^32 + x^22 + x^2 + x + 1 (left-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;
    localparam logic [IW:0] CNT_MAX   = (IW+1)'(MAX_INTERVAL);
    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  OPC_BR    = 7'b1100011;

    state_e             state_q, state_d;
    logic [IW:0]        cnt_q, cnt_d;
    logic [BURST_W-1:0] burst_rem_q, burst_rem_d;
    logic [31:0]        lfsr_q, lfsr_d;

    logic [IW-1:0]      thr;
    logic               ok;
    logic               insert;
    logic               fire;

    assign thr  = lfsr_q[24 +: IW] & {freq_i, 2'b11};
    assign ok   = allow_dummy_i && boundary_i && !ptr_in_if_i;
    assign fire = insert && instr_issued_i;

    always_comb begin
        insert = 1'b0;
        if (enable_i) begin
            case (state_q)
                COUNT:   insert = (cnt_q > {1'b0, thr}) && ok;
                BURST:   insert = ok;
                default: insert = 1'b0;
            endcase
        end
    end

    assign dummy_insert_o = insert;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_rem_d = burst_rem_q;

        if (!enable_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            burst_rem_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                end
                COUNT: begin
                    if (fire) begin
                        if (burst_len_i == '0) begin
                            cnt_d = '0;
                        end else begin
                            burst_rem_d = burst_len_i;
                            state_d     = BURST;
                        end
                    end else if (instr_issued_i && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BURST: begin
                    // Losing permission ends the burst rather than pausing it
                    if (!allow_dummy_i) begin
                        state_d     = COUNT;
                        cnt_d       = '0;
                        burst_rem_d = '0;
                    end else if (fire) begin
                        if (burst_rem_q == BURST_W'(1)) begin
                            state_d = COUNT;
                            cnt_d   = '0;
                        end
                        burst_rem_d = burst_rem_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (cnt_rst_i) begin
                cnt_d = '0;
                if (state_q == BURST) begin
                    state_d     = COUNT;
                    burst_rem_d = '0;
                end
            end
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_we_i) begin
            lfsr_d = (seed_i == '0) ? 32'h1 : seed_i;
        end else if (fire || hint_shift_i) begin
            lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LFSR_TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            burst_rem_q <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_rem_q <= burst_rem_d;
            lfsr_q      <= lfsr_d;
        end
    end

    logic [3:0]  op_en_eff;
    op_e         op;
    logic [4:0]  rs1, rs2;
    logic [12:0] b_imm;

    assign op_en_eff = op_en_i | 4'b0001;
    assign rs1       = lfsr_q[12:8];
    assign rs2       = lfsr_q[20:16];
    // Non-inserted branch acts as a hint to PC+2; an inserted one must not redirect
    assign b_imm     = insert ? 13'd0 : 13'd2;

    always_comb begin
        op = op_e'(lfsr_q[1:0]);
        if (!op_en_eff[lfsr_q[1:0]]) begin
            op = OP_ADD;
        end
        case (op)
            OP_MUL:  dummy_instr_o = {7'b0000001, rs2, rs1, 3'b000, 5'd0, OPC_OP};
            OP_AND:  dummy_instr_o = {7'b0000000, rs2, rs1, 3'b111, 5'd0, OPC_OP};
            OP_BLTU: dummy_instr_o = {b_imm[12], b_imm[10:5], rs2, rs1, 3'b110,
                                      b_imm[4:1], b_imm[11], OPC_BR};
            default: dummy_instr_o = {7'b0000000, rs2, rs1, 3'b000, 5'd0, OPC_OP};
        endcase
    end

endmodule

// File: tb/tb_cv32e41s_dummy_instr_burst.sv
// Directed bench for the burst dummy-instruction generator: trigger, decode,
// burst/abort, counter saturation, blocking and reset behaviour.
module tb_cv32e41s_dummy_instr_burst;

    localparam logic [31:0] SEED = 32'h2BAD_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, allow, boundary, ptr, issued, hshift, cnt_rst, seed_we;
    logic [3:0]  freq;
    logic [3:0]  op_en;
    logic [2:0]  burst_len;
    logic [31:0] seed;
    logic        insert;
    logic [31:0] instr;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cv32e41s_dummy_instr_burst #(
        .MAX_INTERVAL(64), .BURST_W(3), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .allow_dummy_i(allow),
        .boundary_i(boundary), .ptr_in_if_i(ptr), .instr_issued_i(issued),
        .hint_shift_i(hshift), .cnt_rst_i(cnt_rst), .freq_i(freq), .op_en_i(op_en),
        .burst_len_i(burst_len), .seed_i(seed), .seed_we_i(seed_we),
        .dummy_insert_o(insert), .dummy_instr_o(instr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        enable = 0; allow = 1; boundary = 1; ptr = 0; issued = 0; hshift = 0;
        cnt_rst = 0; freq = 0; op_en = 4'hF; burst_len = 0; seed = 0; seed_we = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Reset, load seed 1, enable: leaves FSM in COUNT with cnt=0, lfsr=1
    task automatic setup_seed1();
        init_inputs();
        do_reset();
        enable = 1; seed = 32'h1; seed_we = 1;
        tick();
        seed_we = 0;
    endtask

    task automatic test_reset();
        init_inputs();
        do_reset();
        #1;
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL reset_insert got %b want 0", insert); end
        ncmp++; if (instr !== 32'h02D8_0033) begin nerr++; $display("FAIL reset_instr got %h want 02d80033", instr); end
        ncmp++; if (dut.state_q !== 2'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", dut.state_q); end
        ncmp++; if (dut.cnt_q !== 7'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", dut.cnt_q); end
        ncmp++; if (dut.lfsr_q !== SEED) begin nerr++; $display("FAIL reset_lfsr got %h want %h", dut.lfsr_q, SEED); end
    endtask

    task automatic test_basic_trigger();
        setup_seed1();
        #1;
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL trig_pre got %b want 0", insert); end
        issued = 1;
        tick();
        issued = 0;
        #1;
        ncmp++; if (insert !== 1'b1) begin nerr++; $display("FAIL trig_insert got %b want 1", insert); end
        ncmp++; if (instr !== 32'h0200_0033) begin nerr++; $display("FAIL trig_mul got %h want 02000033", instr); end
        ncmp++; if (dut.cnt_q !== 7'd1) begin nerr++; $display("FAIL trig_cnt got %0d want 1", dut.cnt_q); end
    endtask

    task automatic test_opcode_fallback();
        op_en = 4'b1101;
        #1;
        ncmp++; if (instr !== 32'h0000_0033) begin nerr++; $display("FAIL fallback_add got %h want 00000033", instr); end
        op_en = 4'hF;
    endtask

    task automatic test_branch_imm();
        seed = 32'h3; seed_we = 1;
        tick();
        seed_we = 0;
        #1;
        ncmp++; if (insert !== 1'b1) begin nerr++; $display("FAIL br_insert got %b want 1", insert); end
        ncmp++; if (instr !== 32'h0000_6063) begin nerr++; $display("FAIL br_imm0 got %h want 00006063", instr); end
        enable = 0;
        tick();
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL br_noins got %b want 0", insert); end
        ncmp++; if (instr !== 32'h0000_6163) begin nerr++; $display("FAIL br_imm2 got %h want 00006163", instr); end
        ncmp++; if (dut.state_q !== 2'd0) begin nerr++; $display("FAIL br_idle got %0d want 0", dut.state_q); end
    endtask

    task automatic test_zero_seed();
        seed = 32'h0; seed_we = 1;
        tick();
        seed_we = 0;
        ncmp++; if (dut.lfsr_q !== 32'h1) begin nerr++; $display("FAIL zero_seed got %h want 00000001", dut.lfsr_q); end
    endtask

    task automatic test_hint_shift();
        setup_seed1();
        issued = 1;
        tick();
        hshift = 1;
        tick();
        hshift = 0; issued = 0;
        ncmp++; if (dut.lfsr_q !== 32'h2) begin nerr++; $display("FAIL hint_once got %h want 00000002", dut.lfsr_q); end
        ncmp++; if (dut.cnt_q !== 7'd0) begin nerr++; $display("FAIL hint_cnt got %0d want 0", dut.cnt_q); end
        hshift = 1;
        tick();
        hshift = 0;
        ncmp++; if (dut.lfsr_q !== 32'h4) begin nerr++; $display("FAIL hint_alone got %h want 00000004", dut.lfsr_q); end
    endtask

    task automatic test_burst();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h0200_0033;
        exp_instr[1] = 32'h0000_7033;
        exp_instr[2] = 32'h0000_0033;
        setup_seed1();
        issued = 1;
        tick();
        burst_len = 2;
        for (int i = 0; i < 3; i++) begin
            ncmp++; if (insert !== 1'b1) begin nerr++; $display("FAIL burst_ins%0d got %b want 1", i, insert); end
            ncmp++; if (instr !== exp_instr[i]) begin nerr++; $display("FAIL burst_instr%0d got %h want %h", i, instr, exp_instr[i]); end
            tick();
        end
        issued = 0;
        #1;
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL burst_end_ins got %b want 0", insert); end
        ncmp++; if (dut.lfsr_q !== 32'h8) begin nerr++; $display("FAIL burst_lfsr got %h want 00000008", dut.lfsr_q); end
        ncmp++; if (dut.state_q !== 2'd1) begin nerr++; $display("FAIL burst_state got %0d want 1", dut.state_q); end
        ncmp++; if (dut.cnt_q !== 7'd0) begin nerr++; $display("FAIL burst_cnt got %0d want 0", dut.cnt_q); end
    endtask

    task automatic test_burst_abort();
        issued = 1;
        tick();
        burst_len = 3;
        tick();
        issued = 0; allow = 0;
        #1;
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL abort_ins got %b want 0", insert); end
        ncmp++; if (dut.state_q !== 2'd2) begin nerr++; $display("FAIL abort_in_burst got %0d want 2", dut.state_q); end
        tick();
        allow = 1;
        ncmp++; if (dut.state_q !== 2'd1) begin nerr++; $display("FAIL abort_state got %0d want 1", dut.state_q); end
        ncmp++; if (dut.cnt_q !== 7'd0) begin nerr++; $display("FAIL abort_cnt got %0d want 0", dut.cnt_q); end
    endtask

    task automatic test_cnt_rst();
        issued = 1; ptr = 1;
        tick();
        tick();
        ncmp++; if (dut.cnt_q !== 7'd2) begin nerr++; $display("FAIL cntrst_pre got %0d want 2", dut.cnt_q); end
        cnt_rst = 1;
        tick();
        cnt_rst = 0; issued = 0; ptr = 0;
        ncmp++; if (dut.cnt_q !== 7'd0) begin nerr++; $display("FAIL cntrst got %0d want 0", dut.cnt_q); end
    endtask

    task automatic test_saturation();
        int bad;
        init_inputs();
        do_reset();
        enable = 1; freq = 4'hF;
        tick();
        // thr = 0x2B & 0x3F = 43: inserts only once cnt exceeds 43
        issued = 1; bad = 0;
        for (int i = 0; i < 43; i++) begin
            if (insert !== 1'b0) bad++;
            tick();
        end
        issued = 0;
        #1;
        ncmp++; if (bad != 0) begin nerr++; $display("FAIL sat_early got %0d inserts want 0", bad); end
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL sat_thr_eq got %b want 0", insert); end
        issued = 1;
        tick();
        issued = 0;
        #1;
        ncmp++; if (insert !== 1'b1) begin nerr++; $display("FAIL sat_thr_gt got %b want 1", insert); end
        ptr = 1; issued = 1; bad = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (insert !== 1'b0) bad++;
            tick();
        end
        issued = 0;
        ncmp++; if (bad != 0) begin nerr++; $display("FAIL sat_blocked got %0d inserts want 0", bad); end
        ncmp++; if (dut.cnt_q !== 7'd64) begin nerr++; $display("FAIL sat_cnt got %0d want 64", dut.cnt_q); end
        ptr = 0;
        #1;
        ncmp++; if (insert !== 1'b1) begin nerr++; $display("FAIL sat_unblock got %b want 1", insert); end
        burst_len = 2; issued = 1;
        tick();
        issued = 0;
        ncmp++; if (dut.state_q !== 2'd2) begin nerr++; $display("FAIL dis_in_burst got %0d want 2", dut.state_q); end
        enable = 0;
        #1;
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL dis_ins_now got %b want 0", insert); end
        tick();
        enable = 1;
        #1;
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL dis_ins_next got %b want 0", insert); end
        ncmp++; if (dut.state_q !== 2'd0) begin nerr++; $display("FAIL dis_state got %0d want 0", dut.state_q); end
    endtask

    task automatic test_reset_mid_burst();
        setup_seed1();
        issued = 1;
        tick();
        burst_len = 1;
        tick();
        issued = 0;
        ncmp++; if (dut.state_q !== 2'd2) begin nerr++; $display("FAIL rmb_in_burst got %0d want 2", dut.state_q); end
        rst = 1;
        tick();
        rst = 0;
        #1;
        ncmp++; if (dut.state_q !== 2'd0) begin nerr++; $display("FAIL rmb_state got %0d want 0", dut.state_q); end
        ncmp++; if (dut.lfsr_q !== SEED) begin nerr++; $display("FAIL rmb_lfsr got %h want %h", dut.lfsr_q, SEED); end
        ncmp++; if (insert !== 1'b0) begin nerr++; $display("FAIL rmb_insert got %b want 0", insert); end
    endtask

    initial begin
        rst = 1;
        init_inputs();
        test_reset();
        test_basic_trigger();
        test_opcode_fallback();
        test_branch_imm();
        test_zero_seed();
        test_hint_shift();
        test_burst();
        test_burst_abort();
        test_cnt_rst();
        test_saturation();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
